// File: rtl/ext_in_buffer.sv
// IN-instruction input buffer: small FWFT FIFO filled by an external producer
// over valid/ready and drained by IN (op 4'h7) in the EXE stage.
module ext_in_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       ext_data,
    input  logic                   ext_valid,
    output logic                   ext_ready,
    input  logic [3:0]             op,
    input  logic                   stage_en,
    output logic [WIDTH-1:0]       in_data,
    output logic                   in_stall,
    output logic [$clog2(DEPTH):0] in_count
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] OP_IN = 4'h7;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;

    logic w_is_in;
    logic w_push;
    logic w_pop;
    logic w_empty;

    assign w_is_in = (op == OP_IN);
    assign w_empty = (r_cnt == '0);

    // ready depends only on registered state and rst, never on ext_valid
    assign ext_ready = rst & (r_cnt < FULL_CNT);
    assign w_push    = ext_valid & ext_ready;
    assign w_pop     = w_is_in & stage_en & ~w_empty;

    assign in_data  = r_mem[r_rp];
    assign in_stall = w_is_in & w_empty;
    assign in_count = r_cnt;

    // Storage is never cleared; w_push is already blocked during reset
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= ext_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_in_buffer.sv
// Bench for ext_in_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ext_in_buffer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] ext_data = '0;
    logic             ext_valid = 1'b0;
    logic             ext_ready;
    logic [3:0]       op = 4'h0;
    logic             stage_en = 1'b0;
    logic [WIDTH-1:0] in_data;
    logic             in_stall;
    logic [2:0]       in_count;

    always #5 clk = ~clk;

    ext_in_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ext_data(ext_data), .ext_valid(ext_valid),
        .ext_ready(ext_ready), .op(op), .stage_en(stage_en),
        .in_data(in_data), .in_stall(in_stall), .in_count(in_count)
    );

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] popped[$];
    logic [WIDTH-1:0] pushed[$];
    int  ntests = 0;
    int  nfail  = 0;
    bit  chk_en = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the FIFO model by the same rules, settle
    task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                       input logic [3:0] o, input logic s);
        bit pu, po;
        rst = r; ext_valid = v; ext_data = d; op = o; stage_en = s;
        pu = v && r && (q.size() < DEPTH);
        po = (o == 4'h7) && s && (q.size() != 0);
        @(posedge clk);
        if (!r) begin
            q.delete();
            chk_en = 1;
        end else begin
            if (po) popped.push_back(q.pop_front());
            if (pu) begin
                q.push_back(d);
                pushed.push_back(d);
            end
        end
        #1;
    endtask

    // Continuous compare against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready", 32'(ext_ready), 32'(rst && (q.size() < DEPTH)));
            chk("count", 32'(in_count), 32'(q.size()));
            chk("stall", 32'(in_stall), 32'((op == 4'h7) && (q.size() == 0)));
            if (q.size() != 0)
                chk("data", 32'(in_data), 32'(q[0]));
        end
    end

    initial begin
        int base;
        logic [7:0] b;

        // Reset with IN in EXE: stall follows op, ready held low
        cyc(0, 0, 8'h00, 4'h7, 0);
        cyc(0, 1, 8'h55, 4'h7, 1);
        chk("rst_count", 32'(in_count), 0);
        chk("rst_ready", 32'(ext_ready), 0);
        chk("rst_stall", 32'(in_stall), 1);

        // Two pushes, head is the first byte
        cyc(1, 1, 8'hA5, 4'h0, 0);
        cyc(1, 1, 8'h3C, 4'h0, 0);
        op = 4'h0; ext_valid = 0; #1;
        chk("t1_count", 32'(in_count), 2);
        chk("t1_data", 32'(in_data), 32'h A5);
        chk("t1_stall", 32'(in_stall), 0);
        chk("t1_ready", 32'(ext_ready), 1);
        cyc(1, 0, 8'h00, 4'h7, 1);
        cyc(1, 0, 8'h00, 4'h7, 1);
        chk("t1_pop2", 32'(popped[$]), 32'h3C);

        // Fill, hold off a pending byte while full, then free one slot
        for (int i = 1; i <= 4; i++) cyc(1, 1, 8'(i), 4'h0, 0);
        chk("full_count", 32'(in_count), 4);
        chk("full_ready", 32'(ext_ready), 0);
        cyc(1, 1, 8'h05, 4'h0, 0);
        chk("full_hold", 32'(in_count), 4);
        cyc(1, 1, 8'h05, 4'h7, 1);
        chk("full_pop", 32'(popped[$]), 32'h01);
        chk("full_cnt3", 32'(in_count), 3);
        chk("full_rdy1", 32'(ext_ready), 1);
        chk("full_data", 32'(in_data), 32'h02);
        cyc(1, 1, 8'h05, 4'h0, 0);
        chk("full_acc", 32'(in_count), 4);
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 4'h7, 1);
        chk("full_last", 32'(popped[$]), 32'h05);

        // IN on an empty buffer stalls until a byte arrives
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 4'h7, 1);
            chk("empty_stall", 32'(in_stall), 1);
            chk("empty_cnt", 32'(in_count), 0);
        end
        cyc(1, 1, 8'h7E, 4'h7, 1);
        chk("empty_unstall", 32'(in_stall), 0);
        chk("empty_data", 32'(in_data), 32'h7E);
        cyc(1, 0, 8'h00, 4'h7, 1);
        chk("empty_pop", 32'(popped[$]), 32'h7E);
        chk("empty_cnt0", 32'(in_count), 0);

        // stage_en gates the pop
        cyc(1, 1, 8'h11, 4'h0, 0);
        cyc(1, 1, 8'h22, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'h7, 0);
        cyc(1, 0, 8'h00, 4'h7, 0);
        chk("sen_data", 32'(in_data), 32'h11);
        chk("sen_cnt", 32'(in_count), 2);
        cyc(1, 0, 8'h00, 4'h7, 1);
        chk("sen_next", 32'(in_data), 32'h22);

        // Simultaneous push and pop at cnt=2
        cyc(1, 1, 8'h33, 4'h0, 0);
        cyc(1, 1, 8'h99, 4'h7, 1);
        chk("pp_cnt", 32'(in_count), 2);
        chk("pp_data", 32'(in_data), 32'h33);
        cyc(1, 0, 8'h00, 4'h7, 1);
        cyc(1, 0, 8'h00, 4'h7, 1);
        chk("pp_order", 32'(popped[$]), 32'h99);

        // Stream 10 bytes through to wrap both pointers
        base = popped.size();
        pushed.delete();
        for (int i = 0; i < 12; i++) cyc(1, i < 10, 8'($urandom), 4'h7, 1);
        chk("stream_n", 32'(popped.size() - base), 10);
        for (int i = 0; i < 10 && base + i < popped.size(); i++)
            chk("stream_seq", 32'(popped[base+i]), 32'(pushed[i]));

        // Mid-operation reset with a push offered
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'hC0 + 8'(i), 4'h0, 0);
        chk("mr_cnt3", 32'(in_count), 3);
        rst = 0; ext_valid = 1; ext_data = 8'hEE; #1;
        chk("mr_ready", 32'(ext_ready), 0);
        cyc(0, 1, 8'hEE, 4'h0, 0);
        chk("mr_cnt0", 32'(in_count), 0);
        cyc(1, 1, 8'h5A, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'h7, 1);
        chk("mr_first", 32'(popped[$]), 32'h5A);

        // Randomized traffic, compared every cycle by the monitor
        for (int i = 0; i < 600; i++) begin
            b = 8'($urandom);
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), b,
                ($urandom_range(0, 1) != 0) ? 4'h7 : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0));
        end

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
